// File: rtl/prost_masked_pkg.sv
// Shared constants, width helpers and the unmasked PROST S-box reference.
package prost_masked_pkg;

  localparam int unsigned SBOX_W       = 4;
  localparam int unsigned RND_PER_SBOX = 8;

  typedef logic [SBOX_W-1:0] nibble_t;

  function automatic int unsigned share_width(input int unsigned n);
    return n * SBOX_W;
  endfunction

  function automatic int unsigned rnd_width(input int unsigned n);
    return n * RND_PER_SBOX;
  endfunction

  // Unmasked S-box: input packed {d,c,b,a}, output packed {t,z,y,x}.
  function automatic nibble_t prost_sbox(input nibble_t v);
    logic a, b, c, d, l, m, x, y, z, t;
    a = v[0];
    b = v[1];
    c = v[2];
    d = v[3];
    l = 1'b1 ^ a ^ b ^ c;
    m = 1'b1 ^ a ^ d;
    x = c ^ (l & b) ^ (m & (d ^ (d & c)));
    y = d ^ (l & b) ^ (l & d & c);
    z = a ^ (b & c);
    t = b ^ (c & d);
    return {t, z, y, x};
  endfunction

endpackage

// File: rtl/prost_sbox_masked_core.sv
// One 2-share masked PROST S-box. Stage 1 (registered) holds the linear and
// quadratic share terms plus a refreshed d*c product; the cubic terms are
// formed after the register from the registered shares.
module prost_sbox_masked_core
  import prost_masked_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [SBOX_W-1:0]       share0_in,
  input  logic [SBOX_W-1:0]       share1_in,
  input  logic [RND_PER_SBOX-1:0] rnd_in,
  output logic [SBOX_W-1:0]       share0_out,
  output logic [SBOX_W-1:0]       share1_out
);

  // Per-variable share pairs, index = share domain.
  logic [1:0] a, b, c, d;
  logic [7:0] r;
  logic [1:0] p_n, qx_n, qy_n, qz_n, qt_n;
  logic [1:0] a_q, b_q, p_q, qx_q, qy_q, qz_q, qt_q;
  logic [1:0] x_s, y_s;

  assign a = {share1_in[0], share0_in[0]};
  assign b = {share1_in[1], share0_in[1]};
  assign c = {share1_in[2], share0_in[2]};
  assign d = {share1_in[3], share0_in[3]};
  // r[0] is the MSB of the randomness byte.
  assign r = {<<{rnd_in}};

  // Stage-1 share terms. Operands taken from the other domain arrive blinded
  // (c by r0, d by r1, b by r2); the blind is stripped inside the product.
  // The constants of L and M cancel in the expanded form, so no share-0
  // constant remains.
  always_comb begin
    p_n  = '0;
    qx_n = '0;
    qy_n = '0;
    qz_n = '0;
    qt_n = '0;
    for (int unsigned j = 0; j < 2; j++) begin
      int unsigned o;
      logic bx, cx, dx, ab_x, bc_x, ad_x, dc_x, cd_x;
      o    = (j == 0) ? 1 : 0;
      bx   = b[o] ^ r[2];
      cx   = c[o] ^ r[0];
      dx   = d[o] ^ r[1];
      ab_x = (a[j] & bx) ^ (a[j] & r[2]);
      bc_x = (b[j] & cx) ^ (b[j] & r[0]);
      ad_x = (a[j] & dx) ^ (a[j] & r[1]);
      dc_x = (d[j] & cx) ^ (d[j] & r[0]);
      cd_x = (c[j] & dx) ^ (c[j] & r[1]);
      p_n[j]  = (d[j] & c[j]) ^ dc_x ^ r[3];
      qx_n[j] = c[j] ^ (a[j] & b[j]) ^ ab_x ^ (b[j] & c[j]) ^ bc_x
                ^ (a[j] & d[j]) ^ ad_x ^ r[4];
      qy_n[j] = d[j] ^ (a[j] & b[j]) ^ ab_x ^ (b[j] & c[j]) ^ bc_x ^ r[5];
      qz_n[j] = a[j] ^ (b[j] & c[j]) ^ bc_x ^ r[6];
      qt_n[j] = b[j] ^ (c[j] & d[j]) ^ cd_x ^ r[7];
    end
  end

  // Gadget register: loads only on an accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      p_q  <= '0;
      qx_q <= '0;
      qy_q <= '0;
      qz_q <= '0;
      qt_q <= '0;
    end else if (en) begin
      a_q  <= a;
      b_q  <= b;
      p_q  <= p_n;
      qx_q <= qx_n;
      qy_q <= qy_n;
      qz_q <= qz_n;
      qt_q <= qt_n;
    end
  end

  // Stage-2 cubic terms: x gets a*dc, y gets (a^b)*dc.
  always_comb begin
    x_s = '0;
    y_s = '0;
    for (int unsigned j = 0; j < 2; j++) begin
      int unsigned o;
      logic ab_s;
      o      = (j == 0) ? 1 : 0;
      ab_s   = a_q[j] ^ b_q[j];
      x_s[j] = qx_q[j] ^ (a_q[j] & p_q[j]) ^ (a_q[j] & p_q[o]);
      y_s[j] = qy_q[j] ^ (ab_s & p_q[j]) ^ (ab_s & p_q[o]);
    end
  end

  assign share0_out = {qt_q[0], qz_q[0], y_s[0], x_s[0]};
  assign share1_out = {qt_q[1], qz_q[1], y_s[1], x_s[1]};

endmodule

// File: rtl/prost_sbox_layer_masked.sv
// Parallel layer of masked PROST S-boxes with valid/ready flow control and an
// optional output register stage.
module prost_sbox_layer_masked
  import prost_masked_pkg::*;
#(
  parameter int unsigned NUM_SBOX = 16,
  parameter int unsigned OUT_REG  = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [share_width(NUM_SBOX)-1:0] share0_in,
  input  logic [share_width(NUM_SBOX)-1:0] share1_in,
  input  logic [rnd_width(NUM_SBOX)-1:0]   rnd_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [share_width(NUM_SBOX)-1:0] share0_out,
  output logic [share_width(NUM_SBOX)-1:0] share1_out
);

  localparam int unsigned SW = share_width(NUM_SBOX);

  logic          v1, v_last, advance, load;
  logic [SW-1:0] s1_share0, s1_share1;

  // S1 advances exactly when the final stage is empty or being drained.
  assign in_ready = !v_last || out_ready;
  assign advance  = in_ready;
  assign load     = advance && in_valid;

  // S1 valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) v1 <= 1'b0;
    else if (advance) v1 <= in_valid;
  end

  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_sbox
    prost_sbox_masked_core u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (load),
      .share0_in  (share0_in[i*SBOX_W +: SBOX_W]),
      .share1_in  (share1_in[i*SBOX_W +: SBOX_W]),
      .rnd_in     (rnd_in[i*RND_PER_SBOX +: RND_PER_SBOX]),
      .share0_out (s1_share0[i*SBOX_W +: SBOX_W]),
      .share1_out (s1_share1[i*SBOX_W +: SBOX_W])
    );
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic          v2;
    logic [SW-1:0] s2_share0, s2_share1;

    // S2 output register: data loads only when a valid S1 beat moves up.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v2        <= 1'b0;
        s2_share0 <= '0;
        s2_share1 <= '0;
      end else if (advance) begin
        v2 <= v1;
        if (v1) begin
          s2_share0 <= s1_share0;
          s2_share1 <= s1_share1;
        end
      end
    end

    assign v_last     = v2;
    assign out_valid  = v2;
    assign share0_out = s2_share0;
    assign share1_out = s2_share1;
  end else begin : g_out_comb
    assign v_last     = v1;
    assign out_valid  = v1;
    assign share0_out = s1_share0;
    assign share1_out = s1_share1;
  end

endmodule

// File: tb/tb_prost_sbox_layer_masked.sv
// Self-checking bench: two layers (OUT_REG=0 and OUT_REG=1) with a
// scoreboard built on an unmasked behavioural model of the S-box layer.
module tb_prost_sbox_layer_masked;
  import prost_masked_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         iv   [2];
  logic         irdy [2];
  logic         ov   [2];
  logic         ordy [2];
  logic [63:0]  s0i  [2];
  logic [63:0]  s1i  [2];
  logic [63:0]  s0o  [2];
  logic [63:0]  s1o  [2];
  logic [127:0] rnd  [2];

  int unsigned n_checks, n_errors, cyc;
  bit          lat_chk;
  bit          held [2];
  logic [63:0] prev_s0 [2];
  logic [63:0] prev_s1 [2];
  int unsigned n_out [2];

  typedef struct packed {
    logic [63:0] val;
    logic [31:0] cyc;
  } beat_t;
  beat_t q0[$];
  beat_t q1[$];

  prost_sbox_layer_masked #(.NUM_SBOX(16), .OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .share0_in(s0i[0]), .share1_in(s1i[0]), .rnd_in(rnd[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .share0_out(s0o[0]), .share1_out(s1o[0]));

  prost_sbox_layer_masked #(.NUM_SBOX(16), .OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .share0_in(s0i[1]), .share1_in(s1i[1]), .rnd_in(rnd[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .share0_out(s0o[1]), .share1_out(s1o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Unmasked S-box straight from the L/M equations.
  function automatic logic [3:0] sbox_ref(input logic [3:0] v);
    logic a, b, c, d, l, m;
    a = v[0]; b = v[1]; c = v[2]; d = v[3];
    l = 1'b1 ^ a ^ b ^ c;
    m = 1'b1 ^ a ^ d;
    return {b ^ (c & d), a ^ (b & c), d ^ (l & b) ^ (l & d & c),
            c ^ (l & b) ^ (m & (d ^ (d & c)))};
  endfunction

  function automatic logic [63:0] layer_ref(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox_ref(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int unsigned sz;
      beat_t       b;
      sz = (k == 0) ? q0.size() : q1.size();
      if (!rst_n) begin
        if (k == 0) q0.delete(); else q1.delete();
        held[k] = 1'b0;
      end else begin
        if (held[k]) begin
          check("stall_valid", 64'(ov[k]), 64'd1);
          check("stall_share0", s0o[k], prev_s0[k]);
          check("stall_share1", s1o[k], prev_s1[k]);
        end
        if (sz == 0) begin
          check("empty_valid", 64'(ov[k]), 64'd0);
          check("empty_ready", 64'(irdy[k]), 64'd1);
        end else if (k == 0 || sz >= 2) begin
          check("full_valid", 64'(ov[k]), 64'd1);
          check("full_ready", 64'(irdy[k]), 64'(ordy[k]));
        end
        if (ov[k] && ordy[k] && sz > 0) begin
          if (k == 0) b = q0.pop_front(); else b = q1.pop_front();
          check("recombined", s0o[k] ^ s1o[k], b.val);
          if (lat_chk) check("latency", 64'(cyc - b.cyc), 64'(k + 1));
          n_out[k]++;
        end
        held[k]    = ov[k] && !ordy[k];
        prev_s0[k] = s0o[k];
        prev_s1[k] = s1o[k];
        if (iv[k] && irdy[k]) begin
          b.val = layer_ref(s0i[k] ^ s1i[k]);
          b.cyc = cyc;
          if (k == 0) q0.push_back(b); else q1.push_back(b);
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat to DUT k and hold it until accepted.
  task automatic send(input int k, input logic [63:0] x, input logic [63:0] m,
                      input logic [127:0] r);
    int unsigned n;
    n = 0;
    iv[k] = 1'b1; s1i[k] = m; s0i[k] = x ^ m; rnd[k] = r;
    @(negedge clk);
    while (!irdy[k] && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("send_accept", 64'(irdy[k]), 64'd1);
    step();
    iv[k] = 1'b0;
    rnd[k] = rand128();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  kat_in  [4];
    logic [3:0]  kat_out [4];
    logic [63:0] xv, m, snap0, snap1, fa, fb;
    logic [127:0] rr;
    int          j, last_j, c;
    bit          acc;
    int unsigned start;

    kat_in  = '{4'h0, 4'h1, 4'h2, 4'hF};
    kat_out = '{4'h0, 4'h4, 4'h8, 4'h3};
    n_checks = 0; n_errors = 0; cyc = 0; lat_chk = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; s0i[k] = '0; s1i[k] = '0; rnd[k] = '0;
      held[k] = 1'b0; n_out[k] = 0; prev_s0[k] = '0; prev_s1[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", 64'(ov[k]), 64'd0);
      check("rst_ready", 64'(irdy[k]), 64'd1);
      check("rst_share0", s0o[k], 64'd0);
      check("rst_share1", s1o[k], 64'd0);
    end
    step();

    // Package reference agrees with the equations.
    for (int v = 0; v < 16; v++) check("pkg_ref", 64'(prost_sbox(4'(v))), 64'(sbox_ref(4'(v))));

    // Known answers, OUT_REG=0, one cycle latency.
    lat_chk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xv = {16{kat_in[i]}};
      send(0, xv, rand64(), rand128());
      @(negedge clk);
      check("kat_valid", 64'(ov[0]), 64'd1);
      check("kat_value", s0o[0] ^ s1o[0], {16{kat_out[i]}});
      step();
    end

    // Random streaming on both layers, every nibble sweeps all 16 values.
    for (j = 0; j < 1000; j++) begin
      for (int i = 0; i < 16; i++)
        xv[4*i +: 4] = (j < 16) ? 4'((j + i) % 16) : 4'($urandom_range(0, 15));
      m = rand64();
      rr = rand128();
      for (int k = 0; k < 2; k++) begin
        iv[k] = 1'b1; s1i[k] = m; s0i[k] = xv ^ m; rnd[k] = rr;
      end
      step();
    end
    for (int k = 0; k < 2; k++) iv[k] = 1'b0;
    repeat (5) step();

    // Backpressure: out_ready low on relative cycles 3..6.
    lat_chk = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start = n_out[k];
      j = 0; last_j = -1; c = 0;
      while (j < 8 && c < 40) begin
        ordy[k] = !(c >= 3 && c <= 6);
        if (j != last_j) begin
          for (int i = 0; i < 16; i++) xv[4*i +: 4] = 4'($urandom_range(0, 15));
          m = rand64();
          iv[k] = 1'b1; s1i[k] = m; s0i[k] = xv ^ m; rnd[k] = rand128();
          last_j = j;
        end
        @(negedge clk);
        acc = irdy[k];
        step();
        if (acc) j++;
        c++;
      end
      iv[k] = 1'b0; ordy[k] = 1'b1;
      repeat (4) step();
      check("bp_cycles", 64'(c), 64'd12);
      check("bp_count", 64'(n_out[k] - start), 64'd8);
    end

    // Idle hold with toggling randomness.
    lat_chk = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send(k, rand64(), rand64(), rand128());
      repeat (3) step();
      snap0 = s0o[k];
      snap1 = s1o[k];
      for (int n = 0; n < 10; n++) begin
        rnd[k] = rand128();
        @(negedge clk);
        check("idle_share0", s0o[k], snap0);
        check("idle_share1", s1o[k], snap1);
        step();
      end
    end

    // Reset with two beats in flight in the OUT_REG=1 layer.
    lat_chk = 1'b0;
    ordy[1] = 1'b0;
    send(1, rand64(), rand64(), rand128());
    send(1, rand64(), rand64(), rand128());
    rst_n = 1'b0;
    iv[0] = 1'b1; s1i[0] = rand64(); s0i[0] = rand64(); rnd[0] = rand128();
    step();
    rst_n = 1'b1;
    iv[0] = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(ov[1]), 64'd0);
    check("midrst_share0", s0o[1], 64'd0);
    check("midrst_share1", s1o[1], 64'd0);
    check("midrst_ready", 64'(irdy[1]), 64'd1);
    check("rstcycle_ignored", 64'(ov[0]), 64'd0);
    step();
    ordy[1] = 1'b1;
    repeat (6) step();

    // Mask freshness: same x and share1, different randomness.
    lat_chk = 1'b1;
    m = rand64();
    rr = rand128();
    send(0, {16{4'h5}}, m, rr);
    @(negedge clk);
    fa = s0o[0];
    check("fresh_value_a", s0o[0] ^ s1o[0], {16{4'h5}});
    step();
    send(0, {16{4'h5}}, m, ~rr);
    @(negedge clk);
    fb = s0o[0];
    check("fresh_value_b", s0o[0] ^ s1o[0], {16{4'h5}});
    check("fresh_share0_differs", 64'(fa != fb), 64'd1);
    step();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
